// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and widths for the multi-cycle memory responder
package mem_pkg;
    localparam int WORD_W = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/word_ram_be.sv
// rtl/word_ram_be.sv - single-port word array with byte-enable write and registered read
import mem_pkg::*;

module word_ram_be #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [STRB_W-1:0]              be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_W-1:0]              wdata,
    output logic [WORD_W-1:0]              rdata
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // rdata only moves on a read, so it holds the last loaded word across stores
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < STRB_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/multicycle_mem_responder.sv
// rtl/multicycle_mem_responder.sv - wait-state memory responder for the core's unified port
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
import mem_pkg::*;

module multicycle_mem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_M1 = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [AW-1:0]      lat_idx;
    logic [WORD_W-1:0]  lat_wdata;
    logic [STRB_W-1:0]  lat_wstrb;
    logic [1:0]         lat_off;
    logic               rsp_load;
    logic [WORD_W-1:0]  ram_q;

    logic               accept;
    logic               enter_resp;
    logic               misalign;
    logic               ram_en;
    logic               cur_we;
    logic [AW-1:0]      cur_idx;
    logic [WORD_W-1:0]  cur_wdata;
    logic [STRB_W-1:0]  cur_wstrb;
    logic [1:0]         cur_off;
    logic               unused_addr;

    assign req_ready   = (state == IDLE);
    assign accept      = req_valid && req_ready && rst;
    assign unused_addr = ^req_addr;

    // With zero wait states the array is hit on the accepting edge, so use the live request
    always_comb begin
        cur_we    = lat_we;
        cur_idx   = lat_idx;
        cur_wdata = lat_wdata;
        cur_wstrb = lat_wstrb;
        cur_off   = lat_off;
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_idx   = req_addr[AW+1:2];
            cur_wdata = req_wdata;
            cur_wstrb = req_wstrb;
            cur_off   = req_addr[1:0];
        end
    end

    always_comb begin
        enter_resp = 1'b0;
        if (state == IDLE) begin
            enter_resp = accept && (LATENCY == 0);
        end else if (state == WAIT) begin
            enter_resp = (cnt == '0);
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = (cur_off != 2'b00);
`else
    logic unused_off;
    assign misalign   = 1'b0;
    assign unused_off = ^cur_off;
`endif

    assign ram_en    = enter_resp && !misalign;
    assign rsp_rdata = rsp_load ? ram_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_load  <= 1'b0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            lat_off   <= '0;
        end else begin
            rsp_valid <= enter_resp;
            if (enter_resp) begin
                rsp_load <= !cur_we && !misalign;
                rsp_err  <= misalign;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_idx   <= req_addr[AW+1:2];
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                        lat_off   <= req_addr[1:0];
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    word_ram_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (cur_we),
        .be    (cur_wstrb),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .rdata (ram_q)
    );
endmodule

// File: doc/multicycle_mem_responder.md
Name: multicycle_mem_responder

Overview:
- Memory-side responder for the multi-cycle RISC-V core's unified instruction/data memory port.
- Accepts one fetch, load or store request at a time over a valid/ready handshake.
- Holds the request for a programmable number of wait states, then returns a single-cycle response pulse carrying read data.
- Sits between the core's address mux (PC or ALU result) and the word-organised memory array; it is the responder that the core's fetch/load/store sequencing initiates against.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the array; power of two, at least 2.
- LATENCY, 2, wait-state cycles between request acceptance and response; range 0..15.
- ADDR_W, 32, request address width in bytes.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous assertion, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = fetch/load.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte-lane enables for a store; bit i controls bits 8i+7:8i.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  read word; 0 for stores.
- rsp_err  output  1  misaligned access flag; see Optional Feature.

Behaviour:
- States: IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE. Acceptance occurs on the rising edge where req_valid && req_ready and rst is high.
- Acceptance latches we, word index, wdata, wstrb and addr[1:0] into internal registers.
- Inputs are ignored outside IDLE. The requester need not hold them stable after acceptance.
- Transitions:
  - IDLE -> WAIT on acceptance when LATENCY > 0, loading the wait counter with LATENCY-1.
  - IDLE -> RESP directly on acceptance when LATENCY = 0.
  - WAIT: counter decrements each cycle; WAIT -> RESP on the edge where the counter = 0.
  - RESP -> IDLE unconditionally. There is no response backpressure; the requester must sample rsp_valid when it is high.
- Latency: request accepted at edge k -> rsp_valid high during cycle k+LATENCY+1. req_ready returns high the following cycle.
- Throughput: one request per LATENCY+2 cycles.
- Memory access commits on the edge entering RESP:
  - Stores write only the enabled byte lanes.
  - Loads capture the full word into the rsp_rdata register.
- rsp_rdata and rsp_err are registered and hold their values until the next RESP entry.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses alias (wrap) modulo DEPTH_WORDS*4.
- Store with wstrb = 0000: no array change, normal response.
- Reset (rst low, any state, including mid-WAIT):
  - State -> IDLE; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - A pending request is dropped and a pending store is not committed.
  - req_ready reads 1 once rst deasserts.
  - Array contents are not reset.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Accepted request with addr[1:0] != 00 -> the array is untouched (store suppressed).
  - Response has rsp_rdata = 0 and rsp_err = 1 at the normal latency.
- Undefined:
  - addr[1:0] is ignored and the access goes to the containing word.
  - rsp_err is tied to 0.

Decomposition:
- Shared package mem_pkg holds:
  - state typedef (IDLE/WAIT/RESP);
  - WORD_W = 32, STRB_W = 4;
  - latency counter width = 4.
- Sub-module word_ram_be: single-port DEPTH_WORDS x 32 array with synchronous byte-enable write and registered read, instantiated once.
- The FSM, counter and error logic stay in the top module.

Test Plan:
- LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, wstrb 1111 accepted at edge k -> rsp_valid only in cycle k+3, rsp_rdata 0; then load 0x10 -> rsp_rdata 0xDEADBEEF.
- Byte lanes: store 0x11223344 to 0x20 with wstrb 1111, then store 0x000000AA with wstrb 0001 -> load 0x20 returns 0x112233AA.
- LATENCY=0: back-to-back loads with req_valid held high -> acceptance every 2 cycles, req_ready low during RESP, rsp_valid every other cycle.
- Wrap: DEPTH_WORDS=16, store 0x55 to 0x40 -> load 0x00 returns 0x00000055.
- Reset mid-WAIT: store to 0x30 accepted, rst pulled low one cycle later -> no rsp_valid, load 0x30 afterward returns prior contents, req_ready = 1 after release.
- MISALIGN_TRAP_EN defined: store to 0x32 -> rsp_err = 1, rsp_rdata = 0, word 0x30 unchanged. Undefined: same store writes word 0x30 and rsp_err = 0.
